uart_tx_fpga: RTL
=================

# uart_tx_fpga

Double-buffered UART transmitter. It serialises one byte per frame as: start bit, 8 data bits LSB-first, even parity bit, stop bit, then configurable idle guard bits. Frames match what the team's UART receiver expects, so the two blocks form a loopback pair on the board. The block sits between the fabric-side byte producer (valid/ready handshake) and the TX pin.

## Interface
- clksPerBit, 234: clock cycles per bit time; must be ≥ 2.
- guardBits, 1: idle-high bit times appended after the stop bit. Gives the far receiver time to return to idle before the next start bit. Legal range 0–3.

- i_clkRx  in  1  clock; all logic is on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_txData  in  8  byte to send; sampled only on the accept edge.
- i_txValid  in  1  producer has a byte on i_txData.
- o_txReady  out  1  holding register is empty; a byte is accepted when i_txValid && o_txReady at a rising edge.
- o_txBit  out  1  serial line; idles high; registered.
- o_txBusy  out  1  FSM is not in IDLE.
- o_txDone  out  1  one-cycle pulse when a frame's last guard/stop cycle completes.

## Operation
- Reset values: o_txBit=1, o_txReady=1, o_txBusy=0, o_txDone=0, FSM=IDLE, holding register empty, counters 0.
- States: IDLE → START → DATA → PARITY → STOP → GUARD → IDLE/START.
  - GUARD is skipped when guardBits=0.
- **IDLE:** o_txBit=1.
  - On accept: latch i_txData into the shift register, compute parity = ^i_txData, and go to START.
  - The holding register is not used on this path.
- **START:** o_txBit=0 for clksPerBit cycles.
- **DATA:** o_txBit=shift[0], held for clksPerBit cycles per bit. Shift right after each bit. Bit index runs 0..7, and DATA exits after bit 7's last cycle.
- **PARITY:** o_txBit=parity (even parity, i.e. XOR of the 8 data bits) for clksPerBit cycles.
- **STOP:** o_txBit=1 for clksPerBit cycles.
- **GUARD:** o_txBit=1 for guardBits×clksPerBit cycles.
- **Frame end** (last cycle of GUARD, or of STOP when guardBits=0):
  - If the holding register is full: move it into the shift register, go directly to START (no idle cycle), and clear the holding register.
  - Otherwise, if an accept occurs on this same edge: load the byte directly and go to START.
  - Otherwise: go to IDLE.
- **Holding register:** while the FSM is not IDLE, an accept writes i_txData into the holding register and drives o_txReady=0 from the next cycle.
  - o_txReady returns to 1 the cycle after the holding register is drained into the shift register.
  - o_txReady=0 together with i_txValid=1 is a stall; no byte is taken.
- **Bit counter:** width $clog2(clksPerBit). Counts 0..clksPerBit−1 and wraps to 0 at each bit boundary. A separate guard counter spans guardBits bit times.
- **Illegal FSM encodings:** return to IDLE with o_txBit=1.
- **Reset mid-frame:** o_txBit goes high after the reset edge. The current byte and any held byte are discarded, and o_txReady=1.

## Timing
- **Accept from IDLE:** o_txBit falls at the accept edge (visible the following cycle). Latency is 1 cycle.
- **Frame length:** (11+guardBits)×clksPerBit cycles from the start-bit fall to the next possible start-bit fall.
- **Bit k** (0=start, 1..8=data d0..d7, 9=parity, 10=stop) occupies cycles [k×clksPerBit, (k+1)×clksPerBit) relative to the start-bit fall.
- **o_txDone:** high exactly one cycle, in the cycle after the frame-end edge. This holds for back-to-back frames as well.
- **o_txBusy:** rises with the start bit. It stays high across back-to-back frames and falls the cycle after entering IDLE.
- **Throughput:** two bytes can be accepted one cycle apart; the second byte starts exactly at the first frame's end.
- **Byte order:** bytes are transmitted strictly in acceptance order.

## Test plan
- **Reset:** assert i_reset for 3 cycles → o_txBit=1, o_txReady=1, o_txBusy=0, o_txDone=0 on every cycle, including 20 cycles after release with i_txValid=0.
- **Single frame** (clksPerBit=8, guardBits=1): send 0xA5 → line reads 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, guard 1, each bit exactly 8 cycles. o_txDone pulses once at cycle 96. o_txBusy is high for 96 cycles.
- **Odd parity count:** send 0x07 → parity bit 1. Send 0x00 → parity bit 0 and all data bits 0.
- **Back-to-back:** accept 0x3C then 0xC3 on consecutive cycles.
  - o_txReady drops after the second byte and rises the cycle after the first frame ends.
  - The second start bit begins with no idle gap. Two o_txDone pulses appear, 96 cycles apart.
  - A third i_txValid asserted while o_txReady=0 is not accepted.
- **Reset mid-frame:** assert i_reset during data bit 3 with a byte held → o_txBit=1 next cycle, o_txReady=1, and no frame is emitted afterwards.
- **Loopback:** connect o_txBit to the team's UART receiver (clksPerBit=234, guardBits=1) and send all 256 byte values back-to-back → each o_rxBits matches the sent byte, o_parityError stays 0, and 256 o_rxFinished pulses are seen.

Source files
------------

// File: rtl/uart_tx_fpga_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fpga_if : byte handshake between the fabric producer and TX   |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
interface uart_tx_fpga_if;
  logic [7:0] i_txData;
  logic       i_txValid;
  logic       o_txReady;

  modport master (output i_txData, output i_txValid, input o_txReady);
  modport slave  (input i_txData, input i_txValid, output o_txReady);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fpga.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fpga : double-buffered UART transmitter, 8E1 plus guard bits  |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module uart_tx_fpga #(
  parameter int clksPerBit = 234,
  parameter int guardBits  = 1
) (
  input  wire logic         i_clkRx,
  input  wire logic         i_reset,
  uart_tx_fpga_if.slave     if_tx,
  output logic              o_txBit,
  output logic              o_txBusy,
  output logic              o_txDone
);

  localparam int             c_CNT_W      = $clog2(clksPerBit);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(clksPerBit - 1);
  localparam logic [1:0]     c_GUARD_LAST = 2'((guardBits == 0) ? 0 : guardBits - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GUARD  = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bitIdx;
  logic [1:0]         r_guardCnt;
  logic [7:0]         r_shift;
  logic [7:0]         r_hold;
  logic               r_holdFull;
  logic               r_parity;
  logic               r_txBit;
  logic               r_txDone;
  logic               r_txReady;

  logic w_accept;
  logic w_bitEnd;
  logic w_frameEnd;
  logic w_inFrame;

  assign w_accept   = if_tx.i_txValid && r_txReady;
  assign w_bitEnd   = (r_cnt == c_CNT_LAST);
  assign w_inFrame  = (r_state inside {S_START, S_DATA, S_PARITY, S_STOP, S_GUARD});
  assign w_frameEnd = w_bitEnd &&
                      (((r_state == S_STOP) && (guardBits == 0)) ||
                       ((r_state == S_GUARD) && (r_guardCnt == c_GUARD_LAST)));

  always_ff @(posedge i_clkRx) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_guardCnt <= '0;
      r_shift    <= '0;
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_parity   <= 1'b0;
      r_txBit    <= 1'b1;
      r_txDone   <= 1'b0;
      r_txReady  <= 1'b1;
    end else begin
      r_txDone <= 1'b0;

      // One bit-time counter shared by every in-frame state.
      if (w_inFrame) begin
        r_cnt <= w_bitEnd ? '0 : r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          r_txBit <= 1'b1;
          if (w_accept) begin
            r_shift  <= if_tx.i_txData;
            r_parity <= ^if_tx.i_txData;
            r_state  <= S_START;
            r_txBit  <= 1'b0;
          end
        end
        S_START: begin
          if (w_bitEnd) begin
            r_state  <= S_DATA;
            r_bitIdx <= '0;
            r_txBit  <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bitEnd) begin
            if (r_bitIdx == 3'd7) begin
              r_state <= S_PARITY;
              r_txBit <= r_parity;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_shift  <= r_shift >> 1;
              r_txBit  <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bitEnd) begin
            r_state <= S_STOP;
            r_txBit <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bitEnd && (guardBits != 0)) begin
            r_state    <= S_GUARD;
            r_guardCnt <= '0;
          end
        end
        S_GUARD: begin
          if (w_bitEnd && (r_guardCnt != c_GUARD_LAST)) begin
            r_guardCnt <= r_guardCnt + 2'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_txBit    <= 1'b1;
          r_holdFull <= 1'b0;
          r_txReady  <= 1'b1;
        end
      endcase

      // Frame end takes priority over the per-state updates above.
      if (w_frameEnd) begin
        r_txDone <= 1'b1;
        if (r_holdFull) begin
          r_shift    <= r_hold;
          r_parity   <= ^r_hold;
          r_holdFull <= 1'b0;
          r_txReady  <= 1'b1;
          r_state    <= S_START;
          r_txBit    <= 1'b0;
        end else if (w_accept) begin
          r_shift  <= if_tx.i_txData;
          r_parity <= ^if_tx.i_txData;
          r_state  <= S_START;
          r_txBit  <= 1'b0;
        end else begin
          r_state <= S_IDLE;
          r_txBit <= 1'b1;
        end
      end else if (w_inFrame && w_accept) begin
        r_hold     <= if_tx.i_txData;
        r_holdFull <= 1'b1;
        r_txReady  <= 1'b0;
      end
    end
  end

  assign o_txBit         = r_txBit;
  assign o_txDone        = r_txDone;
  assign o_txBusy        = (r_state != S_IDLE);
  assign if_tx.o_txReady = r_txReady;

endmodule
`default_nettype wire
